// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial pattern generator
//
// Purpose:
//   On start, captures a pattern, a length and a repeat count, then shifts
//   pattern[len]..pattern[0] out MSB first, reps+1 times. A one-cycle done
//   pulse follows the final bit, after which the block returns to IDLE.
//   All outputs are registered, so the first bit appears on dout the cycle
//   after start is sampled.
//
// Configuration:
//   SEQ_GEN_GAP_EN  when defined, one idle GAP cycle (busy=1, dout_valid=0)
//                   separates consecutive repetitions. When undefined, the
//                   GAP state does not exist and repetitions are contiguous.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous reset, active HIGH (1 = reset)
//   start       in   transmit request, sampled only in IDLE
//   pattern     in   [PAT_W-1:0] bits to send, captured on start
//   len         in   [$clog2(PAT_W)-1:0] number of bits minus one
//   reps        in   [REP_W-1:0] extra repetitions (frame sent reps+1 times)
//   dout        out  serial data, 0 whenever dout_valid is 0
//   dout_valid  out  dout carries a pattern bit
//   busy        out  1 in every state except IDLE
//   done        out  single-cycle pulse after the final bit
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int PAT_W = 8,
  parameter int REP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W)-1:0] len,
  input  logic [REP_W-1:0]         reps,
  output logic                     dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W = $clog2(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   idx_dec;

  // State register. Reset wins over everything, including a start in the
  // same cycle and any frame in flight, so an aborted frame never pulses done.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so idx_q always names the bit currently on dout.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    idx_dec = idx_q - LEN_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          len_d   = len;
          rep_d   = reps;
          idx_d   = len;
          state_d = SHIFT;
          dout_d  = pattern[len];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d   = idx_dec;
          dout_d  = pat_q[idx_dec];
          valid_d = 1'b1;
        end else if (rep_q != '0) begin
          // Repetition boundary: counting down the remaining repeats means
          // reps at its maximum never needs a wider counter.
          rep_d = rep_q - REP_ONE;
          idx_d = len_q;
`ifdef SEQ_GEN_GAP_EN
          state_d = GAP;
`else
          dout_d  = pat_q[len_q];
          valid_d = 1'b1;
`endif
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        state_d = SHIFT;
        busy_d  = 1'b1;
        dout_d  = pat_q[len_q];
        valid_d = 1'b1;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- self-checking bench for seq_gen (PAT_W=8, REP_W=4)
//
// A frame model expands each accepted request into the list of per-cycle
// outputs it must produce (bits, optional gaps, done, one idle cycle) and a
// compare process checks the DUT against it every cycle. Directed tests add
// hand-computed literal expectations on the recorded bit stream and timing.
// Build with +define+SEQ_GEN_GAP_EN to check the gap variant.
// -----------------------------------------------------------------------------
module tb_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [3:0] reps;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int passCount;
  int checkCount;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  seq_gen #(.PAT_W(8), .REP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .reps       (reps),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so pass and total counts stay in step.
  task automatic checkOutput(input string name, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Expected outputs for one cycle.
  typedef struct packed {
    logic dout;
    logic valid;
    logic busy;
    logic done;
  } out_t;

  out_t expQ[$];
  out_t expCur;
  bit   modelLive;

  // Expand a request into its whole cycle-by-cycle output trace.
  function automatic void pushFrame(input logic [7:0] p, input int l, input int r);
    out_t e;
    for (int k = 0; k <= r; k++) begin
      for (int i = l; i >= 0; i--) begin
        e = '{dout: p[i], valid: 1'b1, busy: 1'b1, done: 1'b0};
        expQ.push_back(e);
      end
      if (GapEn && k < r) begin
        e = '{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0};
        expQ.push_back(e);
      end
    end
    e = '{dout: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1};
    expQ.push_back(e);
    // One idle cycle after done before the next request can be taken.
    e = '0;
    expQ.push_back(e);
  endfunction

  // Model: a request is taken only when nothing is pending; reset discards
  // everything pending.
  initial begin
    modelLive = 1'b0;
    expCur    = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      expQ.delete();
      expCur    = '0;
      modelLive = 1'b1;
    end else if (expQ.size() != 0) begin
      expCur = expQ.pop_front();
    end else if (start) begin
      pushFrame(pattern, int'(len), int'(reps));
      expCur = expQ.pop_front();
    end else begin
      expCur = '0;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("dout",       int'(dout),       int'(expCur.dout));
      checkOutput("dout_valid", int'(dout_valid), int'(expCur.valid));
      checkOutput("busy",       int'(busy),       int'(expCur.busy));
      checkOutput("done",       int'(done),       int'(expCur.done));
    end
  end

  // Stream recorder, sampled just after each edge; times are relative to
  // the cycle in which start was driven.
  int           cyc;
  int           startCyc;
  logic [127:0] recBits;
  int           recCnt;
  int           firstRel;
  int           doneRel;
  int           doneCnt;
  int           gapCnt;

  initial cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (dout_valid) begin
      recBits = {recBits[126:0], dout};
      recCnt++;
      if (firstRel < 0) firstRel = cyc - startCyc;
    end
    if (busy && !dout_valid && !done) gapCnt++;
    if (done) begin
      doneCnt++;
      if (doneRel < 0) doneRel = cyc - startCyc;
    end
  end

  task automatic clearRecord();
    recBits  = '0;
    recCnt   = 0;
    firstRel = -1;
    doneRel  = -1;
    doneCnt  = 0;
    gapCnt   = 0;
  endtask

  // Drive a one-cycle start from the current negedge.
  task automatic applyStimulus(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
    pattern  = p;
    len      = l;
    reps     = r;
    start    = 1'b1;
    startCyc = cyc;
    clearRecord();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for the done pulse; an expired bound counts as a failure.
  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (doneCnt == 0) checkOutput("done_timeout", 0, 1);
  endtask

  // Generic frame: bit count must be (len+1)*(reps+1), with gaps if enabled.
  task automatic runFrame(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
    @(negedge clk);
    applyStimulus(p, l, r);
    waitDone(300);
    checkOutput("frame_bits", recCnt, (int'(l) + 1) * (int'(r) + 1));
    checkOutput("frame_gaps", gapCnt, GapEn ? int'(r) : 0);
    checkOutput("frame_first", firstRel, 1);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    len        = '0;
    reps       = '0;
    startCyc   = 0;
    clearRecord();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_dout",  int'(dout),       0);
    checkOutput("reset_valid", int'(dout_valid), 0);
    checkOutput("reset_busy",  int'(busy),       0);
    checkOutput("reset_done",  int'(done),       0);
    rst_n = 1'b0;
    @(negedge clk);

    // 8-bit alternating frame, no repeats.
    applyStimulus(8'b10101010, 3'd7, 4'd0);
    waitDone(30);
    checkOutput("aa_first_rel", firstRel, 1);
    checkOutput("aa_count",     recCnt, 8);
    checkOutput("aa_bits",      int'(recBits[7:0]), 8'hAA);
    checkOutput("aa_done_rel",  doneRel, 9);
    @(negedge clk);
    checkOutput("aa_busy_after", int'(busy), 0);

    // 3-bit frame repeated four times.
    @(negedge clk);
    applyStimulus(8'b00000101, 3'd2, 4'd3);
    waitDone(40);
    checkOutput("rep_count",    recCnt, 12);
    checkOutput("rep_bits",     int'(recBits[11:0]), 12'b101101101101);
    checkOutput("rep_gaps",     gapCnt, GapEn ? 3 : 0);
    checkOutput("rep_done_rel", doneRel, GapEn ? 16 : 13);

    // Reset during the 4th bit: outputs clear, no done, immediate restart.
    @(negedge clk);
    applyStimulus(8'b10101010, 3'd7, 4'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_4th_bit_valid", int'(dout_valid), 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checkOutput("abort_valid", int'(dout_valid), 0);
    checkOutput("abort_busy",  int'(busy), 0);
    checkOutput("abort_done",  doneCnt, 0);
    applyStimulus(8'b11110000, 3'd7, 4'd0);
    waitDone(30);
    checkOutput("restart_first", firstRel, 1);
    checkOutput("restart_bits",  int'(recBits[7:0]), 8'hF0);

    // Reset and start together: start ignored.
    @(negedge clk);
    pattern = 8'hFF; len = 3'd7; reps = 4'd0;
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_start_busy",  int'(busy), 0);
    checkOutput("rst_start_valid", int'(dout_valid), 0);

    // Inputs changing mid-frame, start held through DONE, restart in IDLE.
    @(negedge clk);
    applyStimulus(8'b10101010, 3'd7, 4'd0);
    pattern = 8'hFF; len = 3'd3; reps = 4'd5;
    start = 1'b1;
    waitDone(30);
    checkOutput("hold_bits",  int'(recBits[7:0]), 8'hAA);
    checkOutput("hold_count", recCnt, 8);
    @(negedge clk);
    applyStimulus(8'b00111100, 3'd7, 4'd0);
    waitDone(30);
    checkOutput("b2b_first", firstRel, 1);
    checkOutput("b2b_bits",  int'(recBits[7:0]), 8'h3C);

    // Boundaries: single-bit frame, maximum repeat count.
    runFrame(8'b11111110, 3'd0, 4'd0);
    checkOutput("len0_bit", int'(recBits[0]), 0);
    checkOutput("len0_done_rel", doneRel, 2);
    runFrame(8'b00000001, 3'd0, 4'd15);
    checkOutput("len0_max_bits", int'(recBits[15:0]), 16'hFFFF);
    runFrame(8'b11000011, 3'd7, 4'd15);
    checkOutput("max_tail", int'(recBits[15:0]), 16'hC3C3);

    // Further mixed vectors.
    runFrame(8'b10010110, 3'd5, 4'd2);
    checkOutput("mix1_bits", int'(recBits[17:0]), 18'b010110010110010110);
    runFrame(8'b01011010, 3'd3, 4'd1);
    checkOutput("mix2_bits", int'(recBits[7:0]), 8'b10101010);

    // Stream used to drive the sequence detectors: 10101.
    runFrame(8'b00010101, 3'd4, 4'd0);
    checkOutput("loopback_bits", int'(recBits[4:0]), 5'b10101);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PAT_W, default 8, pattern register width in bits; legal range 2..16.
REQ-002 Parameter REP_W, default 4, repeat-count width in bits.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, synchronous active-high reset; 1 means reset.
REQ-005 Port start, input, 1, request to transmit; sampled only in IDLE.
REQ-006 Port pattern, input, PAT_W, bits to transmit; captured on start acceptance.
REQ-007 Port len, input, $clog2(PAT_W), number of bits minus one; bits pattern[len]..pattern[0] are used; captured on start acceptance.
REQ-008 Port reps, input, REP_W, extra repetitions; the frame is sent reps+1 times; captured on start acceptance.
REQ-009 Port dout, output, 1, registered serial data, MSB (pattern[len]) first; drives the sequence detectors' din.
REQ-010 Port dout_valid, output, 1, registered; 1 when dout carries a pattern bit.
REQ-011 Port busy, output, 1, registered; 1 in every state except IDLE.
REQ-012 Port done, output, 1, registered; single-cycle pulse after the final bit.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, GAP and DONE; GAP is reachable only per REQ-028.
REQ-014 IDLE with start=1 SHALL capture pattern, len and reps, load the bit index with len, and move to SHIFT at that edge.
REQ-015 The first bit SHALL be visible on dout with dout_valid=1 in the cycle after start was sampled; latency is 1 cycle.
REQ-016 SHIFT SHALL emit one bit per cycle, pattern[idx], with idx decrementing from len to 0; it SHALL NOT stall.
REQ-017 After the bit at idx=0, if the remaining repetition count is nonzero, the count SHALL decrement, idx SHALL reload to len, and emission SHALL restart at pattern[len] with no idle cycle unless REQ-028 applies.
REQ-018 After the bit at idx=0 with the remaining count at zero, the FSM SHALL enter DONE for exactly one cycle, with done=1, dout_valid=0 and dout=0, then return to IDLE.
REQ-019 Outside SHIFT, dout SHALL be 0 and dout_valid SHALL be 0.
REQ-020 start SHALL be ignored in SHIFT, GAP and DONE; captured values SHALL NOT change mid-transmission even if the inputs change.
REQ-021 The earliest accepted restart is start=1 in the IDLE cycle following DONE, so back-to-back frames are separated by 2 non-valid cycles (DONE, IDLE).
REQ-022 len=0 SHALL emit a 1-bit frame; reps at its maximum of 2^REP_W-1 SHALL emit 2^REP_W frames without counter overflow.
REQ-023 Total valid cycles per transmission SHALL equal (len+1)*(reps+1).

Reset
REQ-024 rst_n=1 at a rising edge SHALL force IDLE, with dout=0, dout_valid=0, busy=0 and done=0 from the next cycle, and SHALL clear idx and the repetition counter.
REQ-025 Reset SHALL take priority over start and over any in-progress transmission; an aborted frame SHALL NOT produce done.
REQ-026 When rst_n=1 and start=1 occur in the same cycle, start SHALL be ignored.

Configuration
REQ-027 The macro SEQ_GEN_GAP_EN SHALL select the inter-repetition gap feature.
REQ-028 With SEQ_GEN_GAP_EN defined, each repetition boundary SHALL insert one GAP cycle (dout=0, dout_valid=0, busy=1); no GAP SHALL be inserted before DONE.
REQ-029 Without SEQ_GEN_GAP_EN, the GAP state and its logic SHALL be absent and repetitions SHALL be contiguous.

Verification
REQ-030 pattern=8'b10101010, len=7, reps=0, start at cycle 0 -> dout 1,0,1,0,1,0,1,0 valid in cycles 1-8; done=1 in cycle 9; busy=0 from cycle 10.
REQ-031 pattern=8'b00000101, len=2, reps=3, gap macro undefined -> 12 contiguous valid bits 101101101101; done in the cycle after the 12th bit.
REQ-032 Same stimulus as REQ-031 with SEQ_GEN_GAP_EN defined -> 101,gap,101,gap,101,gap,101; 15 busy cycles before DONE; dout_valid=0 in each gap.
REQ-033 rst_n=1 during the 4th bit of the REQ-030 frame -> all outputs 0 from the next cycle; no done pulse; a new start accepted the cycle after reset deasserts.
REQ-034 start=1 with pattern changed to 8'hFF while busy in the REQ-030 frame -> output stream unchanged; a start in the IDLE cycle after DONE is accepted.
REQ-035 Loopback to the sequence detectors: pattern 10101 streamed through seq_gen -> detector flags match the same bit sequence when driven directly.
